vx_hpdcache_req_arbiter: RTL and testbench
==========================================

// Module: vx_hpdcache_req_arbiter
// PURPOSE
// Shares the single HPDCache request port between NUM_REQS Vortex requesters using round-robin.
// Extends each request tag with the requester index and routes every response back by that index.
// Tracks outstanding requests and sequences cache flushes: block new requests, drain, flush, resume.
// Sits between the core-side request lanes and the Vortex/HPDCache interface adapter.
// PARAMETERS
// NUM_REQS         4   number of requester lanes (>=2); IW = $clog2(NUM_REQS)
// ADDR_WIDTH       32  request address width
// DATA_WIDTH       32  request/response data width
// TAG_WIDTH        8   per-requester tag width; HPDCache-side tag width is TAG_WIDTH+IW
// MAX_OUTSTANDING  16  in-flight request limit; counter width is $clog2(MAX_OUTSTANDING+1)
// PORTS
// clk              in   1                    clock; all state updates on rising edge
// reset_n          in   1                    asynchronous, active-low reset
// req_valid        in   NUM_REQS             per-lane request valid
// req_ready        out  NUM_REQS             per-lane accept; at most one bit high in a cycle
// req_addr         in   NUM_REQS*ADDR_WIDTH  lane i in bits [i*ADDR_WIDTH +: ADDR_WIDTH]
// req_rw           in   NUM_REQS             1 = write, 0 = read
// req_data         in   NUM_REQS*DATA_WIDTH  write data, packed like req_addr
// req_tag          in   NUM_REQS*TAG_WIDTH   lane tag, packed like req_addr
// rsp_valid        out  NUM_REQS             one-hot response strobe
// rsp_data         out  DATA_WIDTH           response data, shared by all lanes
// rsp_tag          out  TAG_WIDTH            original lane tag
// flush_req        in   1                    flush request; sampled only in IDLE
// flush_busy       out  1                    high whenever state != IDLE
// hpd_req_valid    out  1                    request valid toward HPDCache
// hpd_req_ready    in   1                    HPDCache request accept
// hpd_req_addr     out  ADDR_WIDTH           address of the granted lane
// hpd_req_rw       out  1                    read/write of the granted lane
// hpd_req_data     out  DATA_WIDTH           write data of the granted lane
// hpd_req_tag      out  TAG_WIDTH+IW         {lane index, lane tag}
// hpd_rsp_valid    in   1                    response valid; exactly one per accepted request; no backpressure
// hpd_rsp_data     in   DATA_WIDTH           response data
// hpd_rsp_tag      in   TAG_WIDTH+IW         response tag
// hpd_flush_valid  out  1                    single-cycle flush command pulse
// hpd_flush_done   in   1                    flush completion pulse
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, rr_ptr=0, outstanding=0.
//   All outputs are 0 during reset.
// - Grant is combinational: the first valid lane at or after rr_ptr, wrapping from NUM_REQS-1 to 0.
// - can_issue = (state==IDLE) && !flush_req && (outstanding < MAX_OUTSTANDING).
// - hpd_req_valid = can_issue && |req_valid.
// - req_ready[g] = can_issue && hpd_req_ready, for the granted lane g only.
// - hpd_req_* muxes lane g; hpd_req_tag = {g[IW-1:0], lane g tag}.
// - Fire = hpd_req_valid && hpd_req_ready; on fire, rr_ptr <= g+1 (mod NUM_REQS). Otherwise rr_ptr holds.
// - Output fields of lane g must not change while valid is held; the grant is stable without a handshake.
// - outstanding: +1 on fire, -1 on hpd_rsp_valid, unchanged when both occur in the same cycle.
//   Saturates at 0 (a stray response after reset does not underflow).
// - Response path has 0-cycle latency:
//   - idx = hpd_rsp_tag[TAG_WIDTH+IW-1:TAG_WIDTH]; rsp_valid[idx] = hpd_rsp_valid.
//   - rsp_tag = hpd_rsp_tag[TAG_WIDTH-1:0]; rsp_data = hpd_rsp_data.
//   - If idx >= NUM_REQS, the response is dropped and the counter still decrements.
// - FSM:
//   - IDLE  -> DRAIN  when flush_req=1; no grant that cycle (flush has priority).
//   - DRAIN -> FLUSH  when outstanding==0; always at least one cycle in DRAIN.
//   - FLUSH -> WAIT   unconditionally; hpd_flush_valid=1 only in FLUSH.
//   - WAIT  -> IDLE   on hpd_flush_done. A done pulse seen in any other state is ignored.
// - flush_req in any state other than IDLE is ignored (not queued).
// - Responses keep being routed in every state.
// - Reset mid-flush returns to IDLE with no hpd_flush_valid issued.
// TESTING
// - All 4 lanes valid continuously, ready=1 -> grants 0,1,2,3,0 on consecutive cycles; hpd_req_tag[9:8] follows.
// - Lane 2 only, rr_ptr=3 -> lane 2 granted (wrap); next rr_ptr=3.
// - 16 fires, no responses -> hpd_req_valid=0 at outstanding=16; one response -> issue resumes next cycle.
// - hpd_rsp_tag=10'h2A5 -> rsp_valid=4'b0100, rsp_tag=8'hA5; fire and response in the same cycle -> count unchanged.
// - 3 outstanding, flush_req pulse -> DRAIN until the 3rd response, then one-cycle hpd_flush_valid;
//   requests blocked until hpd_flush_done.
// - Assert reset_n=0 in WAIT -> flush_busy=0 and outputs 0 immediately; after release, requests issue normally.

Source files
------------

// File: rtl/vx_hpdcache_req_arbiter_if.sv
// Bus interfaces around the HPDCache request arbiter.
//   vx_core_req_if : NUM_REQS packed request lanes plus the shared response return.
//                    master = core-side requesters, slave = arbiter.
//   vx_hpd_req_if  : single HPDCache request/response port.
//                    master = arbiter, slave = HPDCache adapter.
//                    TAG_WIDTH here is the extended tag width (lane tag + lane index).

interface vx_core_req_if #(
  parameter int unsigned NUM_REQS   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 8
);
  logic [NUM_REQS-1:0]            req_valid;
  logic [NUM_REQS-1:0]            req_ready;
  logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQS-1:0]            req_rw;
  logic [NUM_REQS*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag;
  logic [NUM_REQS-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]          rsp_data;
  logic [TAG_WIDTH-1:0]           rsp_tag;

  modport master (
    output req_valid, req_addr, req_rw, req_data, req_tag,
    input  req_ready, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_addr, req_rw, req_data, req_tag,
    output req_ready, rsp_valid, rsp_data, rsp_tag
  );
endinterface

interface vx_hpd_req_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 10
);
  logic                  hpd_req_valid;
  logic                  hpd_req_ready;
  logic [ADDR_WIDTH-1:0] hpd_req_addr;
  logic                  hpd_req_rw;
  logic [DATA_WIDTH-1:0] hpd_req_data;
  logic [TAG_WIDTH-1:0]  hpd_req_tag;
  logic                  hpd_rsp_valid;
  logic [DATA_WIDTH-1:0] hpd_rsp_data;
  logic [TAG_WIDTH-1:0]  hpd_rsp_tag;

  modport master (
    output hpd_req_valid, hpd_req_addr, hpd_req_rw, hpd_req_data, hpd_req_tag,
    input  hpd_req_ready, hpd_rsp_valid, hpd_rsp_data, hpd_rsp_tag
  );

  modport slave (
    input  hpd_req_valid, hpd_req_addr, hpd_req_rw, hpd_req_data, hpd_req_tag,
    output hpd_req_ready, hpd_rsp_valid, hpd_rsp_data, hpd_rsp_tag
  );
endinterface

// File: rtl/vx_hpdcache_req_arbiter.sv
// Round-robin arbiter sharing one HPDCache request port among NUM_REQS lanes.
// Request tags are extended with the lane index; responses are routed back by
// that index with zero latency. Outstanding requests are counted, and cache
// flushes are sequenced as block -> drain -> flush command -> wait for done.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   core             lane requests in / lane responses out (vx_core_req_if.slave)
//   hpd              HPDCache request out / response in (vx_hpd_req_if.master)
//   flush_req        flush request, honoured only while idle
//   flush_busy       high whenever a flush sequence is in progress
//   hpd_flush_valid  one-cycle flush command toward the cache
//   hpd_flush_done   flush completion pulse from the cache

module vx_hpdcache_req_arbiter #(
  parameter int unsigned NUM_REQS        = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned TAG_WIDTH       = 8,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  vx_core_req_if.slave      core,
  vx_hpd_req_if.master      hpd,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic              hpd_flush_valid,
  input  logic              hpd_flush_done
);

  localparam int unsigned IW = $clog2(NUM_REQS);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FLUSH,
    ST_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q;
  logic [CW-1:0]   outstanding_q;
  logic            lock_q;
  logic [IW-1:0]   lock_idx_q;

  logic            search_vld;
  logic [IW-1:0]   search_idx;
  int unsigned     cand;
  logic [IW-1:0]   grant_idx;
  int unsigned     gi;
  logic            any_valid;
  logic            can_issue;
  logic            fire;
  logic [IW-1:0]   rsp_idx;
  int unsigned     ri;

  // First valid lane at or after rr_ptr, wrapping.
  always_comb begin
    search_vld = 1'b0;
    search_idx = '0;
    cand       = 0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_REQS;
      if (!search_vld && core.req_valid[cand]) begin
        search_vld = 1'b1;
        search_idx = IW'(cand);
      end
    end
  end

  // A lane that was offered but not accepted keeps the grant while it stays
  // valid, so a lane becoming valid ahead of it cannot change the fields
  // presented to the cache mid-handshake.
  assign grant_idx = (lock_q && core.req_valid[lock_idx_q]) ? lock_idx_q : search_idx;
  assign gi        = int'(grant_idx);
  assign any_valid = |core.req_valid;

  // reset_n is folded in so nothing is presented while reset is held, even
  // though IDLE would otherwise allow issue.
  assign can_issue = reset_n && (state_q == ST_IDLE) && !flush_req &&
                     (outstanding_q < CW'(MAX_OUTSTANDING));
  assign fire      = hpd.hpd_req_valid && hpd.hpd_req_ready;

  always_comb begin
    hpd.hpd_req_valid = can_issue && any_valid;
    hpd.hpd_req_addr  = '0;
    hpd.hpd_req_rw    = 1'b0;
    hpd.hpd_req_data  = '0;
    hpd.hpd_req_tag   = '0;
    core.req_ready    = '0;
    if (reset_n) begin
      hpd.hpd_req_addr = core.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      hpd.hpd_req_rw   = core.req_rw[gi];
      hpd.hpd_req_data = core.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      hpd.hpd_req_tag  = {grant_idx, core.req_tag[gi*TAG_WIDTH +: TAG_WIDTH]};
    end
    if (can_issue && any_valid && hpd.hpd_req_ready) begin
      core.req_ready[gi] = 1'b1;
    end
  end

  // Response routing, zero latency; out-of-range indices are dropped.
  assign rsp_idx = hpd.hpd_rsp_tag[TAG_WIDTH+IW-1:TAG_WIDTH];
  assign ri      = int'(rsp_idx);

  always_comb begin
    core.rsp_valid = '0;
    core.rsp_data  = '0;
    core.rsp_tag   = '0;
    if (reset_n) begin
      core.rsp_data = hpd.hpd_rsp_data;
      core.rsp_tag  = hpd.hpd_rsp_tag[TAG_WIDTH-1:0];
      if (hpd.hpd_rsp_valid && (ri < NUM_REQS)) begin
        core.rsp_valid[ri] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q      <= '0;
      outstanding_q <= '0;
      lock_q        <= 1'b0;
      lock_idx_q    <= '0;
    end else begin
      if (fire) begin
        rr_ptr_q <= (gi == NUM_REQS - 1) ? '0 : grant_idx + IW'(1);
      end
      if (fire && !hpd.hpd_rsp_valid) begin
        outstanding_q <= outstanding_q + CW'(1);
      end else if (!fire && hpd.hpd_rsp_valid && (outstanding_q != '0)) begin
        outstanding_q <= outstanding_q - CW'(1);
      end
      lock_q     <= hpd.hpd_req_valid && !hpd.hpd_req_ready;
      lock_idx_q <= grant_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    flush_busy      = (state_q != ST_IDLE);
    hpd_flush_valid = 1'b0;
    case (state_q)
      ST_IDLE:  if (flush_req) state_d = ST_DRAIN;
      ST_DRAIN: if (outstanding_q == '0) state_d = ST_FLUSH;
      ST_FLUSH: begin
        hpd_flush_valid = 1'b1;
        state_d         = ST_WAIT;
      end
      ST_WAIT:  if (hpd_flush_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vx_hpdcache_req_arbiter.sv
// Directed bench for vx_hpdcache_req_arbiter with hand-computed expectations.
module tb_vx_hpdcache_req_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 8;
  localparam int unsigned MO = 16;

  logic clk = 1'b0;
  logic reset_n;
  logic flush_req;
  logic flush_busy;
  logic hpd_flush_valid;
  logic hpd_flush_done;

  int total = 0;
  int bad   = 0;
  int fires;

  always #5 clk = ~clk;

  vx_core_req_if #(.NUM_REQS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) core_if ();
  vx_hpd_req_if  #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW + 2)) hpd_if ();

  vx_hpdcache_req_arbiter #(
    .NUM_REQS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .core            (core_if),
    .hpd             (hpd_if),
    .flush_req       (flush_req),
    .flush_busy      (flush_busy),
    .hpd_flush_valid (hpd_flush_valid),
    .hpd_flush_done  (hpd_flush_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed grant sequence with all four lanes valid from rr_ptr=0.
  logic [9:0] exp_tag1 [5] = '{10'h010, 10'h111, 10'h212, 10'h313, 10'h010};
  logic [3:0] exp_rdy1 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [31:0] exp_addr1 [5] = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002,
                                 32'h1000_0003, 32'h1000_0000};

  initial begin
    reset_n              = 1'b0;
    flush_req            = 1'b0;
    hpd_flush_done       = 1'b0;
    core_if.req_valid    = 4'hF;
    core_if.req_rw       = 4'b1010;
    core_if.req_addr     = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    core_if.req_data     = {32'h0000_00D3, 32'h0000_00D2, 32'h0000_00D1, 32'h0000_00D0};
    core_if.req_tag      = {8'h13, 8'h12, 8'h11, 8'h10};
    hpd_if.hpd_req_ready = 1'b1;
    hpd_if.hpd_rsp_valid = 1'b1;
    hpd_if.hpd_rsp_tag   = 10'h2A5;
    hpd_if.hpd_rsp_data  = 32'h1234_5678;

    step();
    step();
    check("rst_hpd_valid", hpd_if.hpd_req_valid, 1'b0);
    check("rst_req_ready", core_if.req_ready, 4'b0000);
    check("rst_busy", flush_busy, 1'b0);
    check("rst_flush_valid", hpd_flush_valid, 1'b0);
    check("rst_rsp_valid", core_if.rsp_valid, 4'b0000);
    check("rst_hpd_tag", hpd_if.hpd_req_tag, 10'h000);

    // Release; stray response must not underflow the counter.
    reset_n              = 1'b1;
    core_if.req_valid    = 4'b0000;
    hpd_if.hpd_rsp_tag   = 10'h011;
    #1;
    check("stray_rsp_route", core_if.rsp_valid, 4'b0001);
    step();
    hpd_if.hpd_rsp_valid = 1'b0;

    // Round robin over all lanes: 5 fires, rr ends at 1.
    core_if.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_tag", hpd_if.hpd_req_tag, exp_tag1[k]);
      check("rr_ready", core_if.req_ready, exp_rdy1[k]);
      check("rr_addr", hpd_if.hpd_req_addr, exp_addr1[k]);
      step();
    end

    // Lane 2 only: granted from rr=1, then again from rr=3 via wrap.
    core_if.req_valid = 4'b0100;
    #1;
    check("lane2_from_rr1", hpd_if.hpd_req_tag, 10'h212);
    check("lane2_data", hpd_if.hpd_req_data, 32'h0000_00D2);
    step();
    #1;
    check("wrap_grant", hpd_if.hpd_req_tag, 10'h212);
    check("wrap_ready", core_if.req_ready, 4'b0100);
    check("wrap_rw", hpd_if.hpd_req_rw, 1'b0);
    step();
    core_if.req_valid    = 4'b1100;
    hpd_if.hpd_req_ready = 1'b0;
    #1;
    check("rr_after_wrap", hpd_if.hpd_req_tag, 10'h313);
    check("ready_low_no_accept", core_if.req_ready, 4'b0000);
    check("valid_no_accept", hpd_if.hpd_req_valid, 1'b1);
    check("lane3_rw", hpd_if.hpd_req_rw, 1'b1);
    step();

    // Response routing (outstanding 7 -> 6).
    core_if.req_valid    = 4'b0000;
    hpd_if.hpd_rsp_valid = 1'b1;
    hpd_if.hpd_rsp_tag   = 10'h2A5;
    hpd_if.hpd_rsp_data  = 32'hCAFE_F00D;
    #1;
    check("rsp_valid_2a5", core_if.rsp_valid, 4'b0100);
    check("rsp_tag_2a5", core_if.rsp_tag, 8'hA5);
    check("rsp_data", core_if.rsp_data, 32'hCAFE_F00D);
    step();

    // Fire and response together: count stays 6.
    core_if.req_valid    = 4'b1000;
    hpd_if.hpd_req_ready = 1'b1;
    hpd_if.hpd_rsp_tag   = 10'h344;
    #1;
    check("both_rsp_valid", core_if.rsp_valid, 4'b1000);
    check("both_req_valid", hpd_if.hpd_req_valid, 1'b1);
    step();

    // Fill to the limit: exactly 10 more fires.
    hpd_if.hpd_rsp_valid = 1'b0;
    core_if.req_valid    = 4'hF;
    fires = 0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (!hpd_if.hpd_req_valid) break;
      fires++;
      step();
    end
    check("fill_to_max", fires, 10);
    check("blocked_at_max", hpd_if.hpd_req_valid, 1'b0);
    check("blocked_ready", core_if.req_ready, 4'b0000);

    hpd_if.hpd_rsp_valid = 1'b1;
    hpd_if.hpd_rsp_tag   = 10'h133;
    #1;
    check("max_rsp_route", core_if.rsp_valid, 4'b0010);
    check("blocked_same_cycle", hpd_if.hpd_req_valid, 1'b0);
    step();
    hpd_if.hpd_rsp_valid = 1'b0;
    hpd_if.hpd_req_ready = 1'b0;
    #1;
    check("resume_after_rsp", hpd_if.hpd_req_valid, 1'b1);

    // Drain 12 responses: 15 -> 3 outstanding.
    hpd_if.hpd_rsp_valid = 1'b1;
    hpd_if.hpd_rsp_tag   = 10'h001;
    for (int i = 0; i < 12; i++) step();

    // Flush with 3 outstanding.
    hpd_if.hpd_rsp_valid = 1'b0;
    hpd_if.hpd_req_ready = 1'b1;
    flush_req            = 1'b1;
    #1;
    check("flush_priority", hpd_if.hpd_req_valid, 1'b0);
    check("flush_priority_rdy", core_if.req_ready, 4'b0000);
    step();
    flush_req            = 1'b0;
    hpd_flush_done       = 1'b1;
    hpd_if.hpd_rsp_valid = 1'b1;
    hpd_if.hpd_rsp_tag   = 10'h155;
    #1;
    check("drain_busy", flush_busy, 1'b1);
    check("drain_block", hpd_if.hpd_req_valid, 1'b0);
    check("drain_route", core_if.rsp_valid, 4'b0010);
    step();
    hpd_flush_done = 1'b0;
    #1;
    check("drain_rsp2", hpd_flush_valid, 1'b0);
    step();
    #1;
    check("drain_rsp3", hpd_flush_valid, 1'b0);
    step();
    hpd_if.hpd_rsp_valid = 1'b0;
    #1;
    check("drain_min_cycle", hpd_flush_valid, 1'b0);
    check("drain_min_busy", flush_busy, 1'b1);
    step();
    #1;
    check("flush_pulse", hpd_flush_valid, 1'b1);
    step();
    flush_req = 1'b1;
    #1;
    check("flush_one_cycle", hpd_flush_valid, 1'b0);
    check("wait_busy", flush_busy, 1'b1);
    check("wait_block", hpd_if.hpd_req_valid, 1'b0);
    step();
    flush_req      = 1'b0;
    hpd_flush_done = 1'b1;
    #1;
    check("wait_hold", flush_busy, 1'b1);
    step();
    hpd_flush_done       = 1'b0;
    hpd_if.hpd_req_ready = 1'b0;
    #1;
    check("resume_idle", flush_busy, 1'b0);
    check("resume_valid", hpd_if.hpd_req_valid, 1'b1);

    // Second flush, reset while in WAIT.
    flush_req = 1'b1;
    #1;
    step();
    flush_req = 1'b0;
    #1;
    step();
    #1;
    check("flush2_pulse", hpd_flush_valid, 1'b1);
    step();
    #1;
    check("in_wait", flush_busy, 1'b1);
    reset_n              = 1'b0;
    hpd_if.hpd_req_ready = 1'b1;
    #1;
    check("rst_wait_busy", flush_busy, 1'b0);
    check("rst_wait_valid", hpd_if.hpd_req_valid, 1'b0);
    check("rst_wait_ready", core_if.req_ready, 4'b0000);
    check("rst_wait_flush", hpd_flush_valid, 1'b0);
    check("rst_wait_addr", hpd_if.hpd_req_addr, 32'h0);
    step();
    #1;
    check("rst_hold_flush", hpd_flush_valid, 1'b0);
    step();
    reset_n = 1'b1;
    #1;
    check("post_rst_valid", hpd_if.hpd_req_valid, 1'b1);
    check("post_rst_tag", hpd_if.hpd_req_tag, 10'h010);
    check("post_rst_busy", flush_busy, 1'b0);
    step();
    #1;
    check("post_rst_next", hpd_if.hpd_req_tag, 10'h111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
